// File: rtl/spi_arb_pkg.sv
// Shared types and idle levels for the SPI bus arbiter: FSM states, owner
// encoding and the SPI mode-0 idle pin levels.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEM    = 2'd1,
        PERIPH = 2'd2,
        GUARD  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_MEM    = 2'd1,
        OWN_PERIPH = 2'd2
    } owner_t;

    localparam logic [7:0] CS_IDLE   = 8'hFF;
    localparam logic       SCLK_IDLE = 1'b0;
    localparam logic       MOSI_IDLE = 1'b0;

    function automatic owner_t owner_of(input state_t s);
        case (s)
            MEM:     return OWN_MEM;
            PERIPH:  return OWN_PERIPH;
            default: return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/spi_bus_mux.sv
// Combinational owner-to-pins select. Only the owner's SPI drive reaches the
// pads; the non-owner's chip-select field is forced inactive.
module spi_bus_mux
    import spi_arb_pkg::*;
(
    input  owner_t      owner,
    input  logic        mem_sclk,
    input  logic        mem_mosi,
    input  logic [1:0]  mem_cs_n,
    input  logic        periph_sclk,
    input  logic        periph_mosi,
    input  logic [5:0]  periph_cs_n,
    output logic        bus_sclk,
    output logic        bus_mosi,
    output logic [7:0]  bus_cs_n
);

    always_comb begin
        bus_sclk = SCLK_IDLE;
        bus_mosi = MOSI_IDLE;
        bus_cs_n = CS_IDLE;
        case (owner)
            OWN_MEM: begin
                bus_sclk = mem_sclk;
                bus_mosi = mem_mosi;
                bus_cs_n = {6'h3F, mem_cs_n};
            end
            OWN_PERIPH: begin
                bus_sclk = periph_sclk;
                bus_mosi = periph_mosi;
                bus_cs_n = {periph_cs_n, 2'b11};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Transaction-granular arbiter for the shared SPI pins: memory priority,
// bounded peripheral starvation, guard gap after every release, sticky CS flag.
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int GUARD_CYCLES = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_req,
    input  logic        mem_done,
    output logic        mem_gnt,
    input  logic        mem_sclk,
    input  logic        mem_mosi,
    input  logic [1:0]  mem_cs_n,
    input  logic        periph_req,
    input  logic        periph_done,
    output logic        periph_gnt,
    input  logic        periph_sclk,
    input  logic        periph_mosi,
    input  logic [5:0]  periph_cs_n,
    output logic        bus_sclk,
    output logic        bus_mosi,
    output logic [7:0]  bus_cs_n,
    output logic [1:0]  owner,
    output logic        cs_err,
    output state_t      state,
    output logic [$clog2(STARVE_LIMIT + 1)-1:0] starve_cnt
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [GW-1:0] GUARD_LAST = (GUARD_CYCLES > 0) ? GW'(GUARD_CYCLES - 1) : '0;
    localparam state_t        RELEASE_ST = (GUARD_CYCLES == 0) ? IDLE : GUARD;

    // Handshake: an engine raises req and holds it; the grant stays until the
    // owner pulses done or drops req, after which the bus always passes through release.

    // Reset asserts asynchronously and releases on a clock edge.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    state_t          state_q, state_d;
    owner_t          owner_q;
    logic [SW-1:0]   starve_q, starve_d;
    logic [GW-1:0]   guard_q, guard_d;
    logic            cs_err_q, cs_err_d;
    logic            mem_gnt_q, periph_gnt_q;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_NONE;
            mem_gnt_q    <= 1'b0;
            periph_gnt_q <= 1'b0;
            starve_q     <= '0;
            guard_q      <= '0;
            cs_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_of(state_d);
            mem_gnt_q    <= (state_d == MEM);
            periph_gnt_q <= (state_d == PERIPH);
            starve_q     <= starve_d;
            guard_q      <= guard_d;
            cs_err_q     <= cs_err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        guard_d  = guard_q;
        case (state_q)
            IDLE: begin
                if (periph_req && (!mem_req || starve_q == STARVE_MAX)) begin
                    state_d  = PERIPH;
                    starve_d = '0;
                end else if (mem_req) begin
                    state_d = MEM;
                    if (periph_req && starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
                end
            end
            MEM: begin
                guard_d = '0;
                if (mem_done || !mem_req) state_d = RELEASE_ST;
            end
            PERIPH: begin
                guard_d = '0;
                if (periph_done || !periph_req) state_d = RELEASE_ST;
            end
            GUARD: begin
                if (guard_q == GUARD_LAST) state_d = IDLE;
                else                       guard_d = guard_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // A chip select low from any engine that does not currently own the bus.
    always_comb begin
        cs_err_d = cs_err_q
                 | ((owner_q != OWN_MEM)    && !(&mem_cs_n))
                 | ((owner_q != OWN_PERIPH) && !(&periph_cs_n));
    end

    spi_bus_mux u_mux (
        .owner       (owner_q),
        .mem_sclk    (mem_sclk),
        .mem_mosi    (mem_mosi),
        .mem_cs_n    (mem_cs_n),
        .periph_sclk (periph_sclk),
        .periph_mosi (periph_mosi),
        .periph_cs_n (periph_cs_n),
        .bus_sclk    (bus_sclk),
        .bus_mosi    (bus_mosi),
        .bus_cs_n    (bus_cs_n)
    );

    assign mem_gnt    = mem_gnt_q;
    assign periph_gnt = periph_gnt_q;
    assign owner      = owner_q;
    assign cs_err     = cs_err_q;
    assign state      = state_q;
    assign starve_cnt = starve_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: cycle table with scoreboard queue, then sequences
// for starvation, contention, mid-transaction reset and zero-guard release.
module tb_spi_bus_arbiter;
    import spi_arb_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       mem_req, mem_done, mem_sclk, mem_mosi;
    logic [1:0] mem_cs_n;
    logic       periph_req, periph_done, periph_sclk, periph_mosi;
    logic [5:0] periph_cs_n;

    logic       mem_gnt, periph_gnt, bus_sclk, bus_mosi, cs_err;
    logic [7:0] bus_cs_n;
    logic [1:0] owner;
    state_t     state;
    logic [2:0] starve_cnt;

    logic       g0_mem_gnt, g0_periph_gnt, g0_bus_sclk, g0_bus_mosi, g0_cs_err;
    logic [7:0] g0_bus_cs_n;
    logic [1:0] g0_owner;
    state_t     g0_state;
    logic [2:0] g0_starve_cnt;

    spi_bus_arbiter #(.GUARD_CYCLES(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_done(mem_done), .mem_gnt(mem_gnt),
        .mem_sclk(mem_sclk), .mem_mosi(mem_mosi), .mem_cs_n(mem_cs_n),
        .periph_req(periph_req), .periph_done(periph_done), .periph_gnt(periph_gnt),
        .periph_sclk(periph_sclk), .periph_mosi(periph_mosi), .periph_cs_n(periph_cs_n),
        .bus_sclk(bus_sclk), .bus_mosi(bus_mosi), .bus_cs_n(bus_cs_n),
        .owner(owner), .cs_err(cs_err), .state(state), .starve_cnt(starve_cnt)
    );

    spi_bus_arbiter #(.GUARD_CYCLES(0), .STARVE_LIMIT(4)) dut_g0 (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_done(mem_done), .mem_gnt(g0_mem_gnt),
        .mem_sclk(mem_sclk), .mem_mosi(mem_mosi), .mem_cs_n(mem_cs_n),
        .periph_req(periph_req), .periph_done(periph_done), .periph_gnt(g0_periph_gnt),
        .periph_sclk(periph_sclk), .periph_mosi(periph_mosi), .periph_cs_n(periph_cs_n),
        .bus_sclk(g0_bus_sclk), .bus_mosi(g0_bus_mosi), .bus_cs_n(g0_bus_cs_n),
        .owner(g0_owner), .cs_err(g0_cs_err), .state(g0_state), .starve_cnt(g0_starve_cnt)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [14:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference for pad levels given the owner that should hold the bus.
    function automatic logic [9:0] bus_model(input logic [1:0] own, input logic [1:0] mcs,
                                             input logic [5:0] pcs, input logic msclk,
                                             input logic mmosi, input logic psclk,
                                             input logic pmosi);
        if (own == 2'd1) return {6'h3F, mcs, msclk, mmosi};
        if (own == 2'd2) return {pcs, 2'b11, psclk, pmosi};
        return {8'hFF, 1'b0, 1'b0};
    endfunction

    typedef struct {
        logic       mreq, mdone, preq, pdone;
        logic [1:0] own;
    } vec_t;

    function automatic vec_t mk(input logic mreq, input logic mdone, input logic preq,
                                input logic pdone, input logic [1:0] own);
        vec_t v;
        v.mreq = mreq; v.mdone = mdone; v.preq = preq; v.pdone = pdone; v.own = own;
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic apply(input int idx, input vec_t v, input logic [1:0] cur);
        logic [14:0] got, want;
        @(negedge clk);
        mem_req     = v.mreq;
        mem_done    = v.mdone;
        periph_req  = v.preq;
        periph_done = v.pdone;
        mem_sclk    = 1'($urandom_range(0, 1));
        mem_mosi    = 1'($urandom_range(0, 1));
        periph_sclk = 1'($urandom_range(0, 1));
        periph_mosi = 1'($urandom_range(0, 1));
        mem_cs_n    = (cur == 2'd1 && v.own == 2'd1) ? 2'($urandom_range(0, 2)) : 2'b11;
        periph_cs_n = (cur == 2'd2 && v.own == 2'd2) ? 6'($urandom_range(0, 62)) : 6'h3F;
        exp_q.push_back({v.own == 2'd1, v.own == 2'd2, v.own, 1'b0,
                         bus_model(v.own, mem_cs_n, periph_cs_n, mem_sclk, mem_mosi,
                                   periph_sclk, periph_mosi)});
        @(posedge clk);
        #1;
        got  = {mem_gnt, periph_gnt, owner, cs_err, bus_cs_n, bus_sclk, bus_mosi};
        want = exp_q.pop_front();
        check($sformatf("vec%0d", idx), 32'(got), 32'(want));
    endtask

    vec_t vecs[16];
    int   grants;

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "bench did not complete");
    end

    initial begin
        rst_n = 1'b1;
        mem_req = 0; mem_done = 0; mem_sclk = 0; mem_mosi = 0; mem_cs_n = 2'b11;
        periph_req = 0; periph_done = 0; periph_sclk = 0; periph_mosi = 0; periph_cs_n = 6'h3F;
        #1 rst_n = 1'b0;
        mem_sclk = 1'b1; periph_mosi = 1'b1;
        #2;
        check("rst_mem_gnt", 32'(mem_gnt), 32'd0);
        check("rst_periph_gnt", 32'(periph_gnt), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_bus_cs", 32'(bus_cs_n), 32'hFF);
        check("rst_bus_pins", 32'({bus_sclk, bus_mosi}), 32'd0);
        check("rst_cs_err", 32'(cs_err), 32'd0);
        check("rst_starve", 32'(starve_cnt), 32'd0);
        repeat (3) @(negedge clk);
        mem_sclk = 0; periph_mosi = 0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_state", 32'(state), 32'(IDLE));

        // Simultaneous request, guard timing, stray dones, request drop.
        vecs[0]  = mk(1, 0, 1, 0, 2'd1);
        vecs[1]  = mk(1, 1, 1, 0, 2'd0);
        vecs[2]  = mk(0, 0, 1, 0, 2'd0);
        vecs[3]  = mk(0, 0, 1, 0, 2'd0);
        vecs[4]  = mk(0, 0, 1, 0, 2'd2);
        vecs[5]  = mk(0, 0, 1, 0, 2'd2);
        vecs[6]  = mk(0, 1, 1, 1, 2'd0);
        vecs[7]  = mk(0, 0, 0, 0, 2'd0);
        vecs[8]  = mk(0, 0, 0, 0, 2'd0);
        vecs[9]  = mk(1, 0, 0, 0, 2'd1);
        vecs[10] = mk(1, 0, 0, 1, 2'd1);
        vecs[11] = mk(0, 0, 0, 0, 2'd0);
        vecs[12] = mk(0, 0, 0, 0, 2'd0);
        vecs[13] = mk(1, 0, 0, 0, 2'd0);
        vecs[14] = mk(1, 0, 0, 0, 2'd1);
        vecs[15] = mk(1, 1, 0, 0, 2'd0);
        begin
            logic [1:0] cur;
            cur = 2'd0;
            for (int i = 0; i < 16; i++) begin
                apply(i, vecs[i], cur);
                cur = vecs[i].own;
            end
        end
        check("table_starve", 32'(starve_cnt), 32'd0);

        // Starvation bound: memory keeps re-requesting while periph waits.
        @(negedge clk);
        mem_req = 1; periph_req = 1; mem_done = 0; periph_done = 0;
        mem_sclk = 0; mem_mosi = 0; periph_sclk = 0; periph_mosi = 0;
        grants = 0;
        for (int i = 0; i < 200 && !periph_gnt; i++) begin
            @(negedge clk);
            if (mem_gnt && !mem_done) begin
                mem_done = 1;
                grants++;
            end else begin
                mem_done = 0;
            end
        end
        check("starve_periph_gnt", 32'(periph_gnt), 32'd1);
        check("starve_mem_grants", 32'(grants), 32'd4);
        check("starve_cnt_clear", 32'(starve_cnt), 32'd0);
        check("starve_owner", 32'(owner), 32'd2);
        mem_req = 0;

        // Contention: memory drives CS while the peripheral owns the bus.
        mem_cs_n = 2'b00; periph_cs_n = 6'b111011;
        #1;
        check("iso_bus_cs", 32'(bus_cs_n), 32'hEF);
        check("iso_err_before", 32'(cs_err), 32'd0);
        @(posedge clk);
        #1;
        check("iso_err_set", 32'(cs_err), 32'd1);
        @(negedge clk);
        mem_cs_n = 2'b11; periph_cs_n = 6'h3F; periph_done = 1; periph_req = 0;
        @(negedge clk);
        periph_done = 0;
        repeat (4) @(negedge clk);
        check("iso_err_sticky", 32'(cs_err), 32'd1);
        check("iso_owner_none", 32'(owner), 32'd0);

        // Reset in the middle of a memory transaction.
        mem_req = 1;
        for (int i = 0; i < 20 && !mem_gnt; i++) @(negedge clk);
        check("mrst_granted", 32'(mem_gnt), 32'd1);
        mem_cs_n = 2'b10;
        #1;
        check("mrst_bus_cs", 32'(bus_cs_n), 32'hFE);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_mem_gnt", 32'(mem_gnt), 32'd0);
        check("mrst_owner", 32'(owner), 32'd0);
        check("mrst_bus_cs_idle", 32'(bus_cs_n), 32'hFF);
        check("mrst_cs_err", 32'(cs_err), 32'd0);
        @(negedge clk);
        mem_req = 0; mem_cs_n = 2'b11;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("mrst_state_idle", 32'(state), 32'(IDLE));
        check("mrst_owner_after", 32'(owner), 32'd0);

        // Zero guard: next owner granted one edge after the release edge.
        mem_req = 1;
        for (int i = 0; i < 20 && !g0_mem_gnt; i++) @(negedge clk);
        check("g0_mem_granted", 32'(g0_mem_gnt), 32'd1);
        mem_done = 1; mem_req = 0; periph_req = 1;
        @(posedge clk);
        #1;
        mem_done = 0;
        check("g0_release", 32'({g0_mem_gnt, g0_periph_gnt, g0_owner}), 32'd0);
        @(posedge clk);
        #1;
        check("g0_periph_gnt", 32'(g0_periph_gnt), 32'd1);
        check("g0_owner", 32'(g0_owner), 32'd2);
        check("g2_still_guard", 32'(periph_gnt), 32'd0);
        periph_req = 0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_bus_arbiter.md
# spi_bus_arbiter

Arbitrates the shared SPI pins (SCLK, MOSI, chip selects) between the SPI memory controller and the SPI peripheral engine, replacing the plain busy-based mux at the top level. Grants are transaction-granular, never preemptive. Memory has priority, with a starvation bound for the peripheral engine and a guard gap between owners. A sticky flag reports any chip select driven by an engine that does not own the bus.

## Interface
- GUARD_CYCLES, 2: idle bus cycles inserted after every release (0 allowed).
- STARVE_LIMIT, 4: consecutive memory grants won while periph_req pending before the peripheral gets priority (≥1).
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert and synchronous release, active-low.
- mem_req  in  1  memory controller requests the bus; held until done.
- mem_done  in  1  one-cycle pulse: memory transaction complete, CS already high.
- mem_gnt  out  1  memory controller owns the bus.
- mem_sclk, mem_mosi  in  1 each  memory engine SPI drive.
- mem_cs_n  in  2  [0]=RAM, [1]=FLASH.
- periph_req, periph_done, periph_gnt  in/in/out  1 each  same protocol as memory side.
- periph_sclk, periph_mosi  in  1 each  peripheral engine SPI drive.
- periph_cs_n  in  6  peripheral chip selects.
- bus_sclk, bus_mosi  out  1 each  to pads.
- bus_cs_n  out  8  [1:0]=mem_cs_n, [7:2]=periph_cs_n.
- owner  out  2  0=none, 1=mem, 2=periph.
- cs_err  out  1  sticky contention flag.

## Operation
- States:
  - IDLE: no grant.
  - MEM: mem_gnt=1, owner=1.
  - PERIPH: periph_gnt=1, owner=2.
  - GUARD: no grant.
- IDLE → MEM when mem_req and not (periph_req and starve_cnt==STARVE_LIMIT).
- IDLE → PERIPH when periph_req and (not mem_req or starve_cnt==STARVE_LIMIT).
- IDLE stays IDLE when there is no request.
- starve_cnt:
  - Increments (saturating) on each IDLE→MEM taken while periph_req=1.
  - Clears on IDLE→PERIPH.
  - Width $clog2(STARVE_LIMIT+1).
- MEM/PERIPH → GUARD on the owner's done pulse or on deassertion of the owner's req, whichever comes first. Goes straight to IDLE if GUARD_CYCLES=0.
- Non-owner done pulses are ignored. The owner's req re-asserted in the same cycle as its done does not extend ownership.
- GUARD holds for exactly GUARD_CYCLES cycles, then goes to IDLE. Requests are not sampled in GUARD.
- Bus mux:
  - Owner's sclk, mosi and cs_n pass through combinationally.
  - The non-owner's CS field is forced all-1.
  - With no owner: bus_sclk=0, bus_mosi=0, bus_cs_n=8'hFF (SPI mode 0 idle).
- cs_err sets when any bit of a non-owner's cs_n is 0, in any state. Cleared only by reset.
- Reset (any time, including mid-transaction):
  - Immediately: grants 0, owner 0, bus idle levels, cs_err 0, starve_cnt 0.
  - Next state: IDLE.

## Timing
- State, grants and owner are registered. The bus mux is combinational on the registered owner.
- Grant latency: req sampled high in IDLE at edge n → gnt high after edge n (visible cycle n+1).
- Release: done sampled at edge m → gnt low after edge m. The bus is idle the same cycle gnt drops.
- Next grant after edge m+GUARD_CYCLES+1 at the earliest. This gives GUARD_CYCLES+1 idle cycles minimum between owners.
- Back-to-back same-owner transactions also pay the guard.
- cs_err is registered: it asserts the cycle after the offending sample.

## Structure
- Package spi_arb_pkg:
  - State enum (IDLE, MEM, PERIPH, GUARD).
  - owner_t encoding (OWN_NONE=0, OWN_MEM=1, OWN_PERIPH=2).
  - Idle constants (CS_IDLE=8'hFF, SCLK_IDLE=0).
- One sub-module is natural: spi_bus_mux, the purely combinational owner→pins select and CS forcing.
- The FSM, counters and error flag stay in spi_bus_arbiter.
- Estimated 150–250 lines of RTL total.

## Test plan
- Reset mid-MEM: mem_gnt=1 with mem_cs_n=2'b10, assert rst_n=0 → same cycle mem_gnt=0, bus_cs_n=8'hFF, owner=0; after release the FSM sits in IDLE.
- Simultaneous request: mem_req=periph_req=1 in IDLE, starve_cnt=0 → owner=1 next cycle. mem_done pulse → 2 idle GUARD cycles plus the IDLE sample cycle → periph_gnt=1.
- Starvation bound: periph_req held high while mem_req keeps re-requesting, STARVE_LIMIT=4 → exactly 4 memory grants, then periph_gnt; starve_cnt returns to 0.
- Mux isolation: owner=2, drive mem_cs_n=2'b00, periph_cs_n=6'b111011 → bus_cs_n=8'b11101111 and cs_err=1 the next cycle, staying 1 until reset.
- Request drop: owner=1, mem_req falls without mem_done → GUARD entered next edge; a stray periph_done while owner=1 has no effect.
- GUARD_CYCLES=0: mem_done at edge m, periph_req high → periph_gnt visible after edge m+1.
